response_burst_park: RTL and testbench

//  Multi-beat successor of the single-response park. Holds whole R bursts (up to MAX_BEATS beats) per UID ({row,col})

---
 rtl/response_park_pkg.sv | 23 ++
 rtl/burst_park_slot.sv | 73 +++++++
 rtl/response_burst_park.sv | 167 ++++++++++++++++
 tb/tb_response_burst_park.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/response_park_pkg.sv
// Shared types and helpers for the multi-beat R-channel response park.
package response_park_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        COMPLETE = 2'd2,
        DRAINING = 2'd3
    } slot_state_e;

    typedef enum logic {
        ENG_IDLE   = 1'b0,
        ENG_STREAM = 1'b1
    } eng_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int unsigned uid_w(input int unsigned rows, input int unsigned cols);
        return $clog2(rows) + $clog2(cols);
    endfunction

endpackage

// File: rtl/burst_park_slot.sv
// One UID slot: holds up to MAX_BEATS beats of a burst and tracks its fill/drain lifecycle.
module burst_park_slot
    import response_park_pkg::*;
#(
    parameter int unsigned MAX_BEATS  = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned TAG_WIDTH  = 4,
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1),
    localparam int unsigned IDX_W     = $clog2(MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_last,
    input  logic                  wr_ovf,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [RESP_WIDTH-1:0] wr_resp,
    input  logic [ID_WIDTH-1:0]   wr_id,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic                  rel_en,
    input  logic                  drain_done,
    input  logic                  flush_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output slot_state_e           state,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [RESP_WIDTH-1:0] rd_resp,
    output logic [ID_WIDTH-1:0]   rd_id,
    output logic [TAG_WIDTH-1:0]  rd_tag
);

    localparam int unsigned BEAT_W = DATA_WIDTH + RESP_WIDTH + ID_WIDTH + TAG_WIDTH;

    logic [BEAT_W-1:0] mem [MAX_BEATS];
    slot_state_e       state_d;
    logic [CNT_W-1:0]  count_d;

    // Truncated bursts carry SLVERR on the forced final beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[IDX_W-1:0]] <= {wr_data, (wr_ovf ? RESP_WIDTH'(RESP_SLVERR) : wr_resp), wr_id, wr_tag};
        end
    end

    assign {rd_data, rd_resp, rd_id, rd_tag} = mem[rd_idx];

    always_comb begin
        state_d = state;
        count_d = count;
        if (flush_en || drain_done) begin
            state_d = FREE;
            count_d = '0;
        end else if (wr_en) begin
            count_d = count + CNT_W'(1);
            state_d = (wr_last || wr_ovf) ? COMPLETE : FILLING;
        end else if (rel_en) begin
            state_d = DRAINING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

endmodule

// File: rtl/response_burst_park.sv
// Parks whole R bursts per UID until ordering logic releases one, then streams it beat by beat.
module response_burst_park
    import response_park_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned MAX_REQ    = NUM_ROWS * NUM_COLS,
    parameter int unsigned MAX_PARKED = MAX_REQ - 1,
    parameter int unsigned MAX_BEATS  = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned RESP_WIDTH = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned TAG_WIDTH  = 4,
    localparam int unsigned UID_W     = uid_w(NUM_ROWS, NUM_COLS),
    localparam int unsigned USED_W    = $clog2(MAX_PARKED + 1),
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1),
    localparam int unsigned IDX_W     = $clog2(MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [UID_W-1:0]      in_uid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [RESP_WIDTH-1:0] in_resp,
    input  logic [ID_WIDTH-1:0]   in_orig_id,
    input  logic [TAG_WIDTH-1:0]  in_tagid,
    input  logic                  in_last,
    input  logic                  rel_valid,
    output logic                  rel_ready,
    input  logic [UID_W-1:0]      rel_uid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_WIDTH-1:0] out_resp,
    output logic [ID_WIDTH-1:0]   out_orig_id,
    output logic [TAG_WIDTH-1:0]  out_tagid,
    output logic                  out_last,
    output logic [UID_W-1:0]      out_uid,
    output logic                  done,
    input  logic                  flush_req,
    input  logic [UID_W-1:0]      flush_uid,
    output logic                  flush_ack,
    output logic                  ovf_err,
    output logic [USED_W-1:0]     used_cnt
);

    slot_state_e           slot_st   [MAX_REQ];
    logic [CNT_W-1:0]      slot_cnt  [MAX_REQ];
    logic [DATA_WIDTH-1:0] slot_data [MAX_REQ];
    logic [RESP_WIDTH-1:0] slot_resp [MAX_REQ];
    logic [ID_WIDTH-1:0]   slot_id   [MAX_REQ];
    logic [TAG_WIDTH-1:0]  slot_tag  [MAX_REQ];

    eng_state_e       eng_q, eng_d;
    logic [UID_W-1:0] uid_q, uid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    slot_state_e in_st, fl_st;
    logic        in_fire, in_open, in_ovf, rel_fire, cur_last;

    assign in_st = slot_st[in_uid];
    assign fl_st = slot_st[flush_uid];

    // A slot being flushed this cycle must not also be filled or released.
    assign in_ready = !rst && !(flush_req && (flush_uid == in_uid))
                    && (((in_st == FREE) && (used_cnt < USED_W'(MAX_PARKED))) || (in_st == FILLING));
    assign in_fire  = in_valid && in_ready;
    assign in_open  = in_fire && (in_st == FREE);
    assign in_ovf   = in_fire && !in_last && (slot_cnt[in_uid] == CNT_W'(MAX_BEATS - 1));
    assign ovf_err  = in_ovf;

    assign rel_ready = !rst && (eng_q == ENG_IDLE) && (slot_st[rel_uid] == COMPLETE)
                     && !(flush_req && (flush_uid == rel_uid));
    assign flush_ack = !rst && flush_req && ((fl_st == FILLING) || (fl_st == COMPLETE));
    assign cur_last  = (CNT_W'(ptr_q) == (slot_cnt[uid_q] - CNT_W'(1)));

    // Stream engine: next state plus the muxed output beat.
    always_comb begin
        eng_d       = eng_q;
        uid_d       = uid_q;
        ptr_d       = ptr_q;
        rel_fire    = 1'b0;
        done        = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_uid     = '0;
        out_data    = '0;
        out_resp    = '0;
        out_orig_id = '0;
        out_tagid   = '0;
        case (eng_q)
            ENG_IDLE: begin
                if (rel_valid && rel_ready) begin
                    eng_d    = ENG_STREAM;
                    uid_d    = rel_uid;
                    ptr_d    = '0;
                    rel_fire = 1'b1;
                end
            end
            ENG_STREAM: begin
                out_valid   = 1'b1;
                out_last    = cur_last;
                out_uid     = uid_q;
                out_data    = slot_data[uid_q];
                out_resp    = slot_resp[uid_q];
                out_orig_id = slot_id[uid_q];
                out_tagid   = slot_tag[uid_q];
                if (out_ready) begin
                    if (cur_last) begin
                        done  = 1'b1;
                        eng_d = ENG_IDLE;
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            default: eng_d = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_q    <= ENG_IDLE;
            uid_q    <= '0;
            ptr_q    <= '0;
            used_cnt <= '0;
        end else begin
            eng_q    <= eng_d;
            uid_q    <= uid_d;
            ptr_q    <= ptr_d;
            used_cnt <= used_cnt + USED_W'(in_open) - USED_W'(done) - USED_W'(flush_ack);
        end
    end

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_slot
        burst_park_slot #(
            .MAX_BEATS  (MAX_BEATS),
            .DATA_WIDTH (DATA_WIDTH),
            .RESP_WIDTH (RESP_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (in_fire && (in_uid == UID_W'(i))),
            .wr_last    (in_last),
            .wr_ovf     (in_ovf),
            .wr_data    (in_data),
            .wr_resp    (in_resp),
            .wr_id      (in_orig_id),
            .wr_tag     (in_tagid),
            .rel_en     (rel_fire && (rel_uid == UID_W'(i))),
            .drain_done (done && (uid_q == UID_W'(i))),
            .flush_en   (flush_ack && (flush_uid == UID_W'(i))),
            .rd_idx     (ptr_q),
            .state      (slot_st[i]),
            .count      (slot_cnt[i]),
            .rd_data    (slot_data[i]),
            .rd_resp    (slot_resp[i]),
            .rd_id      (slot_id[i]),
            .rd_tag     (slot_tag[i])
        );
    end

endmodule

// File: tb/tb_response_burst_park.sv
// Scoreboard bench for response_burst_park: per-UID burst model, beats queued on release.
module tb_response_burst_park;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last;
    logic [3:0]   in_uid, in_orig_id, in_tagid;
    logic [255:0] in_data;
    logic [1:0]   in_resp;
    logic         rel_valid, rel_ready;
    logic [3:0]   rel_uid;
    logic         out_valid, out_ready, out_last;
    logic [255:0] out_data;
    logic [1:0]   out_resp;
    logic [3:0]   out_orig_id, out_tagid, out_uid;
    logic         done, flush_req, flush_ack, ovf_err;
    logic [3:0]   flush_uid, used_cnt;

    always #5 clk = ~clk;

    response_burst_park dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_uid(in_uid), .in_data(in_data),
        .in_resp(in_resp), .in_orig_id(in_orig_id), .in_tagid(in_tagid), .in_last(in_last),
        .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_uid(rel_uid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_resp(out_resp),
        .out_orig_id(out_orig_id), .out_tagid(out_tagid), .out_last(out_last), .out_uid(out_uid),
        .done(done), .flush_req(flush_req), .flush_uid(flush_uid), .flush_ack(flush_ack),
        .ovf_err(ovf_err), .used_cnt(used_cnt)
    );

    typedef struct packed {
        logic [255:0] d;
        logic [1:0]   r;
        logic [3:0]   id;
        logic [3:0]   tag;
        logic         last;
        logic [3:0]   uid;
    } beat_t;

    beat_t mdl [16][4];
    int    mdl_cnt [16];
    beat_t exp_q [$];
    beat_t mon_e, mon_a;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Record an accepted beat; returns whether it should trigger truncation.
    function automatic logic model_accept(input int uid, input logic [255:0] d, input logic [1:0] r,
                                          input logic [3:0] id, input logic [3:0] tag, input logic last);
        beat_t b;
        logic  ovf;
        ovf    = (mdl_cnt[uid] == 3) && !last;
        b.d    = d;
        b.r    = ovf ? 2'b10 : r;
        b.id   = id;
        b.tag  = tag;
        b.last = last || ovf;
        b.uid  = 4'(uid);
        mdl[uid][mdl_cnt[uid]] = b;
        mdl_cnt[uid]++;
        return ovf;
    endfunction

    function automatic void model_release(input int uid);
        for (int k = 0; k < mdl_cnt[uid]; k++) exp_q.push_back(mdl[uid][k]);
        mdl_cnt[uid] = 0;
    endfunction

    function automatic void model_flush(input int uid);
        mdl_cnt[uid] = 0;
    endfunction

    // Output monitor: every handshaken beat is popped and compared.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got uid=%0d with empty scoreboard", out_uid);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = {out_data, out_resp, out_orig_id, out_tagid, out_last, out_uid};
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL out_beat: got uid=%0d resp=%0h id=%0h tag=%0h last=%0b data=%h, required uid=%0d resp=%0h id=%0h tag=%0h last=%0b data=%h",
                             mon_a.uid, mon_a.r, mon_a.id, mon_a.tag, mon_a.last, mon_a.d,
                             mon_e.uid, mon_e.r, mon_e.id, mon_e.tag, mon_e.last, mon_e.d);
                end
            end
        end
    end

    task automatic send_beat(input int uid, input logic last, input logic [1:0] resp);
        int   cyc;
        logic exp_ovf;
        cyc = 0;
        @(negedge clk);
        in_valid = 1'b1; in_uid = 4'(uid); in_data = rnd(); in_resp = resp;
        in_orig_id = 4'($urandom()); in_tagid = 4'($urandom()); in_last = last;
        #1;
        while (!in_ready && cyc < 16) begin
            @(negedge clk); #1; cyc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_timeout: uid=%0d in_ready=%0b, required 1", uid, in_ready);
        end else begin
            exp_ovf = model_accept(uid, in_data, in_resp, in_orig_id, in_tagid, last);
            n_checks++;
            if (ovf_err !== exp_ovf) begin
                n_fail++;
                $display("FAIL ovf_err: uid=%0d got %0b, required %0b", uid, ovf_err, exp_ovf);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_uid(input int uid);
        int cyc;
        cyc = 0;
        @(negedge clk);
        rel_valid = 1'b1; rel_uid = 4'(uid);
        #1;
        while (!rel_ready && cyc < 16) begin
            @(negedge clk); #1; cyc++;
        end
        n_checks++;
        if (rel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_ready_timeout: uid=%0d rel_ready=%0b, required 1", uid, rel_ready);
        end else begin
            model_release(uid);
        end
        @(posedge clk); #1;
        rel_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk); #1; cyc++;
        end while (!done && cyc < 40);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic check_used(input string name, input int exp);
        n_checks++;
        if (used_cnt !== 4'(exp)) begin
            n_fail++;
            $display("FAIL %s: used_cnt=%0d, required %0d", name, used_cnt, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_uid = '0; in_data = '0; in_resp = '0; in_orig_id = '0; in_tagid = '0; in_last = 1'b1;
        rel_valid = 1'b1; rel_uid = '0; out_ready = 1'b1; flush_req = 1'b1; flush_uid = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, rel_ready, out_valid, out_last, done, flush_ack, ovf_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {in_ready,rel_ready,out_valid,out_last,done,flush_ack,ovf_err}=%b, required 0000000",
                     {in_ready, rel_ready, out_valid, out_last, done, flush_ack, ovf_err});
        end
        n_checks++;
        if ({out_data, out_resp, out_orig_id, out_tagid, out_uid} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: out_uid=%0d out_resp=%0h out_data=%h, required all 0", out_uid, out_resp, out_data);
        end
        check_used("reset_used", 0);
        in_valid = 1'b0; in_last = 1'b0; rel_valid = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_three_beat();
        int cyc;
        send_beat(5, 1'b0, 2'b00);
        check_used("three_beat_open", 1);
        send_beat(5, 1'b0, 2'b01);
        send_beat(5, 1'b1, 2'b00);
        check_used("three_beat_parked", 1);
        release_uid(5);
        wait_done(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL three_beat_latency: done after %0d cycles, required 3", cyc);
        end
        @(posedge clk); #1;
        check_used("three_beat_freed", 0);
    endtask

    task automatic test_fill_all();
        int cyc;
        for (int u = 0; u < 15; u++) send_beat(u, 1'b1, 2'(u));
        check_used("fill_used", 15);
        @(negedge clk);
        in_uid = 4'd15;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full_ready: uid 15 in_ready=%0b, required 0", in_ready);
        end
        release_uid(3);
        wait_done(cyc);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_cycle_ready: uid 15 in_ready=%0b, required 0", in_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_after_free_ready: uid 15 in_ready=%0b, required 1", in_ready);
        end
        send_beat(15, 1'b1, 2'b11);
        check_used("fill_refill", 15);
        for (int u = 0; u < 16; u++) begin
            if (u != 3) begin
                release_uid(u);
                wait_done(cyc);
            end
        end
        @(posedge clk); #1;
        check_used("fill_drained", 0);
    endtask

    task automatic test_overflow();
        int cyc;
        for (int b = 0; b < 4; b++) send_beat(2, 1'b0, 2'b01);
        @(negedge clk);
        in_valid = 1'b1; in_uid = 4'd2; in_last = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fifth_ready: in_ready=%0b on truncated slot, required 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        release_uid(2);
        wait_done(cyc);
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL ovf_drain_latency: done after %0d cycles, required 4", cyc);
        end
        send_beat(2, 1'b1, 2'b00);
        check_used("ovf_new_burst", 1);
        @(negedge clk);
        flush_req = 1'b1; flush_uid = 4'd2;
        #1;
        n_checks++;
        if (flush_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flush_ack: got %0b, required 1", flush_ack);
        end
        model_flush(2);
        @(posedge clk); #1;
        flush_req = 1'b0;
        check_used("ovf_flushed", 0);
    endtask

    task automatic test_release_wait();
        int   cyc;
        logic dummy;
        send_beat(7, 1'b0, 2'b00);
        send_beat(7, 1'b0, 2'b01);
        @(negedge clk);
        rel_valid = 1'b1; rel_uid = 4'd7;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (rel_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_filling_rel_ready: cycle %0d got %0b, required 0", k, rel_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b1; in_uid = 4'd7; in_data = rnd(); in_resp = 2'b00;
        in_orig_id = 4'd9; in_tagid = 4'd3; in_last = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, rel_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL wait_last_beat: {in_ready,rel_ready}=%b, required 10", {in_ready, rel_ready});
        end
        dummy = model_accept(7, in_data, in_resp, in_orig_id, in_tagid, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (rel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_complete_rel_ready: got %0b, required 1", rel_ready);
        end
        model_release(7);
        @(posedge clk); #1;
        rel_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_first_beat: out_valid=%0b one cycle after release, required 1", out_valid);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL wait_drain_latency: done %0d cycles after first beat, required 2", cyc);
        end
    endtask

    task automatic test_ready_toggle();
        int           done_at;
        logic         hold_chk;
        logic [255:0] held_data;
        logic         held_last;
        done_at  = 0;
        hold_chk = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(1, (b == 2), 2'(b));
        out_ready = 1'b0;
        release_uid(1);
        for (int c = 1; c <= 10 && done_at == 0; c++) begin
            @(negedge clk);
            out_ready = (c % 2 == 0);
            flush_req = (c == 3);
            flush_uid = 4'd1;
            #1;
            if (c == 3) begin
                n_checks++;
                if (flush_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL toggle_flush_draining: flush_ack=%0b, required 0", flush_ack);
                end
            end
            if (hold_chk) begin
                n_checks++;
                if ({out_valid, out_data, out_last} !== {1'b1, held_data, held_last}) begin
                    n_fail++;
                    $display("FAIL toggle_hold: cycle %0d out_valid=%0b out_last=%0b data=%h, required 1 %0b %h",
                             c, out_valid, out_last, out_data, held_last, held_data);
                end
            end
            hold_chk  = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (done) done_at = c;
        end
        n_checks++;
        if (done_at != 6) begin
            n_fail++;
            $display("FAIL toggle_done_cycle: done at cycle %0d, required 6", done_at);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        out_ready = 1'b1;
        check_used("toggle_freed", 0);
    endtask

    task automatic test_flush_and_drain();
        send_beat(4, 1'b1, 2'b00);
        send_beat(9, 1'b0, 2'b01);
        send_beat(9, 1'b1, 2'b11);
        check_used("flush_drain_parked", 2);
        release_uid(9);
        @(negedge clk);
        @(negedge clk);
        flush_req = 1'b1; flush_uid = 4'd4;
        #1;
        n_checks++;
        if ({done, flush_ack} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_drain_same_cycle: {done,flush_ack}=%b, required 11", {done, flush_ack});
        end
        model_flush(4);
        @(posedge clk); #1;
        flush_req = 1'b0;
        check_used("flush_drain_used", 0);
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 3; b++) send_beat(6, (b == 2), 2'b00);
        release_uid(6);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({out_valid, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_out: out_valid=%0b data=%h, required 0", out_valid, out_data);
        end
        check_used("reset_mid_used", 0);
        exp_q.delete();
        model_flush(6);
        rst = 1'b0;
        @(negedge clk);
        rel_valid = 1'b1; rel_uid = 4'd6; in_uid = 4'd6;
        #1;
        n_checks++;
        if ({rel_ready, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_slot_free: {rel_ready,in_ready}=%b, required 01", {rel_ready, in_ready});
        end
        rel_valid = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 16; u++) mdl_cnt[u] = 0;
        test_reset();
        test_three_beat();
        test_fill_all();
        test_overflow();
        test_release_wait();
        test_ready_toggle();
        test_flush_and_drain();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d beats outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
